// File: rtl/date_disp_pkg.sv
// date_disp_pkg: shared definitions for the date display path.
//   - active-low segment glyphs, ordered {a,b,c,d,e,f,g,dp}
//   - page encoding for the two display pages
//   - snapshot struct holding the six BCD date digits
//   - bcd_to_seg(): digit 0-9 to glyph; values above 9 give a dash
package date_disp_pkg;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // Decimal point is bit 0; lighting it clears that bit (active-low).
  localparam logic [7:0] DP_MASK   = 8'h01;

  typedef enum logic {
    PAGE_MMDD = 1'b0,
    PAGE_YEAR = 1'b1
  } page_e;

  typedef struct packed {
    logic [3:0] year1;
    logic [3:0] year0;
    logic [3:0] month1;
    logic [3:0] month0;
    logic [3:0] day1;
    logic [3:0] day0;
  } date_digits_t;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_debounce_edge.sv
// ssd_debounce_edge: pushbutton conditioner for the page button.
//   clk, rst   : system clock, synchronous active-high reset
//   tick       : sample enable (one pulse per scan slot)
//   btn_async  : raw asynchronous button level
//   stable     : debounced level (set on DEB_LEN ones, cleared on DEB_LEN zeros)
//   rise       : one-clk pulse on the tick where stable goes 0 -> 1
module ssd_debounce_edge
  #(parameter int DEB_LEN = 4)
  (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn_async,
    output logic stable,
    output logic rise
  );

  logic               sync1_q, sync2_q;
  logic [DEB_LEN-1:0] sh_q, sh_d;
  logic               stable_q, stable_d;
  logic               rise_q, rise_d;

  always_comb begin
    sh_d     = sh_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    if (tick) begin
      sh_d = (sh_q << 1) | DEB_LEN'(sync2_q);
      // Mixed history keeps the previous level (hysteresis).
      if (&sh_d)       stable_d = 1'b1;
      else if (~|sh_d) stable_d = 1'b0;
      rise_d = stable_d & ~stable_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sh_q     <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= btn_async;
      sync2_q  <= sync1_q;
      sh_q     <= sh_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
    end
  end

  assign stable = stable_q;
  assign rise   = rise_q;

endmodule

// File: rtl/date_ssd_scanner.sv
// date_ssd_scanner: multiplexes the six BCD date digits onto a 4-digit
// seven-segment display, as page MMDD ("MM.DD", leading month zero blanked)
// or page YEAR ("20YY"). A debounced button toggles the page.
//   clk, rst        : system clock, synchronous active-high reset
//   page_btn        : raw page pushbutton (asynchronous)
//   year1..day0     : live BCD digits from the date counters
//   ssd_ctrl        : active-low anode enables, bit 0 = rightmost digit
//   show            : active-low segments {a,b,c,d,e,f,g,dp}
//   page            : current page, 0 = MMDD, 1 = YEAR
module date_ssd_scanner
  import date_disp_pkg::*;
  #(
    parameter int SCAN_DIV = 100000,
    parameter int DEB_LEN  = 4
  )
  (
    input  logic       clk,
    input  logic       rst,
    input  logic       page_btn,
    input  logic [3:0] year1,
    input  logic [3:0] year0,
    input  logic [3:0] month1,
    input  logic [3:0] month0,
    input  logic [3:0] day1,
    input  logic [3:0] day0,
    output logic [3:0] ssd_ctrl,
    output logic [7:0] show,
    output logic       page
  );

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic          first_q;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  page_e         page_q, page_d;
  date_digits_t  snap_q, snap_d;
  logic [3:0]    ssd_ctrl_q, ssd_ctrl_d;
  logic [7:0]    show_q, show_d;
  logic [7:0]    cur_seg;
  logic          tick;
  logic          deb_stable;
  logic          deb_rise;

  assign tick = (pcnt_q == PW'(SCAN_DIV - 1));

  ssd_debounce_edge #(.DEB_LEN(DEB_LEN)) u_deb (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn_async (page_btn),
    .stable    (deb_stable),
    .rise      (deb_rise)
  );

  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    idx_d  = tick ? idx_q + 2'd1 : idx_q;

    // Latch a whole frame at once so a carry ripple never shows half-updated.
    snap_d = snap_q;
    if (first_q || (tick && idx_q == 2'd3)) begin
      snap_d = '{year1: year1, year0: year0, month1: month1,
                 month0: month0, day1: day1, day0: day0};
    end

    page_d = page_q;
    if (deb_rise) page_d = (page_q == PAGE_MMDD) ? PAGE_YEAR : PAGE_MMDD;

    cur_seg = SEG_BLANK;
    case (idx_q)
      2'd0: cur_seg = (page_q == PAGE_YEAR) ? bcd_to_seg(snap_q.year0)
                                            : bcd_to_seg(snap_q.day0);
      2'd1: cur_seg = (page_q == PAGE_YEAR) ? bcd_to_seg(snap_q.year1)
                                            : bcd_to_seg(snap_q.day1);
      2'd2: cur_seg = (page_q == PAGE_YEAR) ? SEG_0
                                            : (bcd_to_seg(snap_q.month0) & ~DP_MASK);
      2'd3: begin
        if (page_q == PAGE_YEAR)       cur_seg = SEG_2;
        else if (snap_q.month1 == 4'd0) cur_seg = SEG_BLANK;
        else                            cur_seg = bcd_to_seg(snap_q.month1);
      end
      default: cur_seg = SEG_BLANK;
    endcase

    // Stay dark on the snapshot cycle right after reset; digit 0 follows.
    if (first_q) begin
      ssd_ctrl_d = 4'b1111;
      show_d     = SEG_BLANK;
    end else begin
      ssd_ctrl_d = ~(4'b0001 << idx_q);
      show_d     = cur_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q    <= 1'b1;
      pcnt_q     <= '0;
      idx_q      <= 2'd0;
      page_q     <= PAGE_MMDD;
      snap_q     <= '0;
      ssd_ctrl_q <= 4'b1111;
      show_q     <= SEG_BLANK;
    end else begin
      first_q    <= 1'b0;
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      page_q     <= page_d;
      snap_q     <= snap_d;
      ssd_ctrl_q <= ssd_ctrl_d;
      show_q     <= show_d;
    end
  end

  assign ssd_ctrl = ssd_ctrl_q;
  assign show     = show_q;
  assign page     = (page_q == PAGE_YEAR);

endmodule

// File: tb/tb_date_ssd_scanner.sv
// Self-checking bench for date_ssd_scanner with SCAN_DIV=4, DEB_LEN=3.
// Expected digit slots ({ssd_ctrl, show}) are queued by each scenario and
// popped by a negedge monitor whenever the anode pattern changes.
module tb_date_ssd_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       page_btn = 1'b0;
  logic [3:0] year1 = 4'd0, year0 = 4'd0, month1 = 4'd0;
  logic [3:0] month0 = 4'd0, day1 = 4'd0, day0 = 4'd0;
  logic [3:0] ssd_ctrl;
  logic [7:0] show;
  logic       page;

  int checks = 0;
  int passes = 0;

  logic [11:0] exp_q[$];
  logic [3:0]  prev_ctrl = 4'hF;

  always #5 clk = ~clk;

  date_ssd_scanner #(.SCAN_DIV(4), .DEB_LEN(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .page_btn (page_btn),
    .year1    (year1),
    .year0    (year0),
    .month1   (month1),
    .month0   (month0),
    .day1     (day1),
    .day0     (day0),
    .ssd_ctrl (ssd_ctrl),
    .show     (show),
    .page     (page)
  );

  // Scoreboard monitor: each new anode pattern is one digit slot.
  always @(negedge clk) begin
    logic [11:0] e;
    if (ssd_ctrl !== prev_ctrl && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({ssd_ctrl, show} !== e)
        $display("FAIL slot: got ctrl=%b show=%h, want ctrl=%b show=%h",
                 ssd_ctrl, show, e[11:8], e[7:0]);
      else passes++;
    end
    prev_ctrl = ssd_ctrl;
  end

  task automatic wait_ctrl(input logic [3:0] v, input string name);
    int n = 0;
    while (ssd_ctrl !== v && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (ssd_ctrl !== v) begin
      checks++;
      $display("FAIL %s: timeout waiting for ctrl=%b, got %b", name, v, ssd_ctrl);
    end
  endtask

  // Land at the start of an idx=3 slot, before that frame's snapshot edge.
  task automatic sync_frame(input string name);
    wait_ctrl(4'b1011, name);
    wait_ctrl(4'b0111, name);
  endtask

  task automatic wait_change(input string name);
    logic [3:0] old;
    int n = 0;
    old = ssd_ctrl;
    while (ssd_ctrl === old && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (ssd_ctrl === old) begin
      checks++;
      $display("FAIL %s: timeout waiting for digit change, ctrl stuck at %b", name, old);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL %s: %0d expected slots never appeared", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    int n;
    {month1, month0, day1, day0} = {4'd0, 4'd3, 4'd1, 4'd5};
    {year1, year0} = {4'd2, 4'd5};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if ({ssd_ctrl, show, page} !== {4'b1111, 8'hFF, 1'b0})
      $display("FAIL reset_state: got %b %h %b, want 1111 ff 0", ssd_ctrl, show, page);
    else passes++;
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if ({ssd_ctrl, show} !== {4'b1111, 8'hFF})
      $display("FAIL snapshot_cycle_dark: got %b %h, want 1111 ff", ssd_ctrl, show);
    else passes++;
    @(negedge clk); #1;
    checks++; if ({ssd_ctrl, show} !== {4'b1110, 8'h49})
      $display("FAIL first_digit0: got %b %h, want 1110 49", ssd_ctrl, show);
    else passes++;
    exp_q.push_back({4'b1101, 8'h9F});
    exp_q.push_back({4'b1011, 8'h0C});
    exp_q.push_back({4'b0111, 8'hFF});
    drain("reset_frame");
    n = 0;
    while (ssd_ctrl === 4'b0111 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++; if (n !== 4 || ssd_ctrl !== 4'b1110)
      $display("FAIL slot_length: got %0d clk ending in ctrl=%b, want 4 clk then 1110", n, ssd_ctrl);
    else passes++;
  endtask

  task automatic test_midframe_update();
    {month1, month0, day1, day0} = {4'd0, 4'd9, 4'd1, 4'd5};
    sync_frame("midframe_sync");
    exp_q.push_back({4'b1110, 8'h49});
    exp_q.push_back({4'b1101, 8'h9F});
    exp_q.push_back({4'b1011, 8'h08});
    exp_q.push_back({4'b0111, 8'hFF});
    wait_ctrl(4'b1101, "midframe_idx1");
    {month1, month0} = {4'd1, 4'd0};
    drain("midframe_old");
    exp_q.push_back({4'b1110, 8'h49});
    exp_q.push_back({4'b1101, 8'h9F});
    exp_q.push_back({4'b1011, 8'h02});
    exp_q.push_back({4'b0111, 8'h9F});
    drain("midframe_new");
  endtask

  task automatic test_page_toggle();
    {year1, year0} = {4'd2, 4'd4};
    wait_change("toggle_align");
    page_btn = 1'b1;
    // Third tick edge falls 11 clk after this point; page flips one clk later.
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk); #1;
      if (i >= 10) begin
        checks++;
        if (page !== (i == 12))
          $display("FAIL toggle_timing clk%0d: page=%b want %b", i, page, (i == 12));
        else passes++;
      end
    end
    sync_frame("year_sync");
    exp_q.push_back({4'b1110, 8'h99});
    exp_q.push_back({4'b1101, 8'h25});
    exp_q.push_back({4'b1011, 8'h03});
    exp_q.push_back({4'b0111, 8'h25});
    drain("year_frame");
    for (int t = 0; t < 20; t++) begin
      wait_change("hold");
      checks++; if (page !== 1'b1)
        $display("FAIL hold_no_repeat tick%0d: page=%b want 1", t, page);
      else passes++;
    end
    page_btn = 1'b0;
    repeat (6) wait_change("release");
    checks++; if (page !== 1'b1)
      $display("FAIL release_no_action: page=%b want 1", page);
    else passes++;
  endtask

  task automatic test_bounce();
    logic       pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] hist = 3'b000;
    logic       st = 1'b0;
    logic       exp_page = 1'b1;
    for (int k = 0; k < 8; k++) begin
      page_btn = pat[k];
      wait_change("bounce");
      hist = {hist[1:0], pat[k]};
      if (hist == 3'b111 && !st) begin
        st = 1'b1;
        exp_page = ~exp_page;
      end else if (hist == 3'b000) begin
        st = 1'b0;
      end
      checks++; if (page !== exp_page)
        $display("FAIL bounce sample%0d: page=%b want %b", k, page, exp_page);
      else passes++;
    end
    page_btn = 1'b0;
    repeat (4) wait_change("bounce_release");
  endtask

  task automatic test_dash();
    {month1, month0, day1, day0} = {4'd1, 4'd2, 4'd3, 4'hC};
    sync_frame("dash_sync");
    exp_q.push_back({4'b1110, 8'hFD});
    exp_q.push_back({4'b1101, 8'h0D});
    exp_q.push_back({4'b1011, 8'h24});
    exp_q.push_back({4'b0111, 8'h9F});
    drain("dash_frame");
  endtask

  task automatic test_reset_midframe();
    page_btn = 1'b1;
    repeat (4) wait_change("pre_reset_toggle");
    checks++; if (page !== 1'b1)
      $display("FAIL pre_reset_page: page=%b want 1", page);
    else passes++;
    wait_ctrl(4'b1101, "reset_align");
    wait_ctrl(4'b1011, "reset_align");
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if ({ssd_ctrl, show, page} !== {4'b1111, 8'hFF, 1'b0})
      $display("FAIL midframe_reset: got %b %h %b, want 1111 ff 0", ssd_ctrl, show, page);
    else passes++;
    rst = 1'b0;
    // Button held through reset: three fresh samples at tick edges 4, 8, 12.
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk); #1;
      if (i == 1) begin
        checks++; if (ssd_ctrl !== 4'b1111)
          $display("FAIL post_reset_dark: ctrl=%b want 1111", ssd_ctrl);
        else passes++;
      end
      if (i >= 11) begin
        checks++; if (page !== (i == 13))
          $display("FAIL held_through_reset clk%0d: page=%b want %b", i, page, (i == 13));
        else passes++;
      end
    end
    page_btn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_midframe_update();
    test_page_toggle();
    test_bounce();
    test_dash();
    test_reset_midframe();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/date_ssd_scanner.md
# date_ssd_scanner

Downstream display stage of the date counter. It takes the six live BCD date digits (YY MM DD) and time-multiplexes them onto the 4-digit seven-segment display in two pages: MMDD and "20YY". A debounced pushbutton toggles between the pages. Digits are snapshotted once per scan frame so a carry ripple never shows half-updated on the display.

## Interface
Parameters:
- SCAN_DIV, 100000 — clk cycles per digit slot (100 MHz → 1 kHz per digit).
- DEB_LEN, 4 — consecutive equal button samples, one per scan tick, needed to accept a new level.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- page_btn  in  1  raw page pushbutton, asynchronous. It is passed through a 2-FF synchronizer internally.
- year1, year0, month1, month0, day1, day0  in  4 each  BCD digits from the date counters.
- ssd_ctrl  out  4  anode enables, active-low. Bit 0 is the rightmost digit.
- show  out  8  segments {a,b,c,d,e,f,g,dp}, active-low.
- page  out  1  current page: 0 = MMDD, 1 = YEAR.

## Operation
- Prescaler `pcnt` counts 0..SCAN_DIV-1 and wraps to 0. `tick` is asserted for one cycle when `pcnt == SCAN_DIV-1`.
- Digit index `idx` (2 bits) advances 0→1→2→3→0 on each tick.
- Frame snapshot: on the tick where `idx == 3`, and on the first cycle after reset, all six input digits are latched into `snap_*`. The display only ever shows `snap_*`.
- Page MMDD, digit 3..0 content:
  - digit 3: month1, blanked if 0.
  - digit 2: month0, with dp lit.
  - digit 1: day1.
  - digit 0: day0.
- Page YEAR, digit 3..0 content: "2", "0", year1, year0. No dp.
- Decode: 0-9 map to standard glyphs, e.g. 0=8'h03, 1=8'h9F, 2=8'h25, 3=8'h0D, 5=8'h49. Any value above 9 shows a dash (8'hFD). Blank is 8'hFF. dp lit clears bit 0.
- Debounce:
  - Sample the synchronized button on each tick into a DEB_LEN-bit shift register.
  - `stable` goes to 1 when all bits are 1 and to 0 when all bits are 0; otherwise it holds.
  - A rising edge of `stable` toggles `page` exactly once. Holding the button gives no repeat; release gives no action.
- `ssd_ctrl = ~(4'b0001 << idx)` and `show = decode(digit[idx])`. Both are registered.

## Timing
- Reset values:
  - pcnt=0, idx=0, page=0.
  - Shift register all 0, stable=0.
  - snap_* = 0.
  - ssd_ctrl=4'b1111 and show=8'hFF (all dark) while rst is high.
- First cycle after rst falls: snapshot is taken. Outputs show digit 0 from the following cycle.
- Output latency: ssd_ctrl and show change one clk after idx changes, and always change together (no cross-digit glitch).
- Page toggle:
  - `stable` rises on the tick of the DEB_LEN-th consecutive high sample.
  - `page` flips one clk later.
  - The new page appears at the next digit update. No frame restart.
- Snapshot and toggle on the same tick: both take effect; the snapshot is page-independent.
- Inputs changing mid-frame are ignored until the next frame snapshot. Full frame = 4·SCAN_DIV cycles.
- rst mid-frame: everything returns to reset values on the next edge. A button held through reset is accepted only after DEB_LEN high samples following release of rst.

## Structure
- Package `date_disp_pkg` holds:
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK, DP_MASK;
  - page encoding PAGE_MMDD / PAGE_YEAR;
  - a bcd-to-seg decode function.
- One sub-module, `ssd_debounce_edge` (synchronizer, shift register, stable level, rise pulse), clocked by clk and enabled by tick.
- Prescaler, idx, snapshot, page register and output mux stay in the top.

## Test plan
All scenarios use SCAN_DIV=4 and DEB_LEN=3.
- Reset, then release with month=03, day=15 → cycling gives digit0=8'h49, digit1=8'h9F, digit2=8'h0C, digit3=8'hFF. Anodes step 1110→1101→1011→0111, 4 clk each.
- month 09→10 applied mid-frame (idx=1) → digit3 stays blank and digit2 stays "9" until idx wraps. Next frame shows "1" and "0.".
- page_btn held high for 3 ticks → page=1 one clk after the third tick. Display shows 8'h25, 8'h03, year1, year0. Holding for 20 more ticks causes no further toggle.
- Bounce pattern 1,0,1,1,0 on successive ticks → no toggle. Then 1,1,1 → exactly one toggle.
- day0=4'hC → digit0 shows 8'hFD.
- Assert rst during idx=2 on page YEAR → next cycle ssd_ctrl=1111, show=FF, page=0.
